// File: rtl/fft16_ctrl_if.sv
// Bundle between the FFT sequencer and its memory / butterfly / capture logic.
//
// Handshake: there is no ready signal. start is a level request that the
// sequencer samples only while idle; busy stays high for the whole transform
// and done pulses for one cycle after the final write has been issued. A start
// seen while busy or during done is dropped, never queued. rd_en and wr_en are
// single-cycle strobes that qualify their addresses in the same cycle.
interface fft16_ctrl_if #(
    parameter int NBITS = 16
);
    logic             start;
    logic             busy;
    logic             done;
    logic             rd_en;
    logic [3:0]       rd_addr_a;
    logic [3:0]       rd_addr_b;
    logic             wr_en;
    logic [3:0]       wr_addr_a;
    logic [3:0]       wr_addr_b;
    logic [NBITS-1:0] tw_re;
    logic [NBITS-1:0] tw_im;
    logic [1:0]       stage;
    logic [1:0]       dbg_state;

    // Sequencer side
    modport master (
        input  start,
        output busy, done, rd_en, rd_addr_a, rd_addr_b,
        output wr_en, wr_addr_a, wr_addr_b, tw_re, tw_im, stage, dbg_state
    );

    // Memory / butterfly / capture side
    modport slave (
        output start,
        input  busy, done, rd_en, rd_addr_a, rd_addr_b,
        input  wr_en, wr_addr_a, wr_addr_b, tw_re, tw_im, stage, dbg_state
    );
endinterface

// File: rtl/fft16_ctrl.sv
// Sequencer for a 16-point radix-2 DIT FFT: walks 4 stages x 8 butterflies,
// issues in-place reads, presents the twiddle one cycle after the operand data
// (the butterfly registers B ahead of its twiddle product) and writes results
// back through a valid/address delay line matched to memory + butterfly latency.
// Every output comes straight from a flop. MEM_LAT must be at least 1.
module fft16_ctrl #(
    parameter int NBITS   = 16,
    parameter int MEM_LAT = 1,
    parameter int BF_LAT  = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    fft16_ctrl_if.master bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Write-back lags issue by this many cycles; draining the same number of
    // cycles puts the next stage's first read right after the last write.
    localparam int PIPE_D = MEM_LAT + BF_LAT;
    localparam int DW     = $clog2(PIPE_D + 1);

    state_t         state_q, state_d;
    logic [2:0]     j_q, j_d;
    logic [1:0]     stage_q, stage_d;
    logic [DW-1:0]  drain_q, drain_d;
    logic           issue_d;

    logic [3:0]     span, idx, grp, a_d, b_d;
    logic [2:0]     k_d;

    logic           rd_en_q;
    logic [3:0]     ra_q, rb_q;
    logic [2:0]     k_q;
    logic           busy_q, done_q;

    logic           pv [PIPE_D];
    logic [3:0]     pa [PIPE_D];
    logic [3:0]     pb [PIPE_D];
    logic [2:0]     pk [MEM_LAT];

    logic [31:0]    tw_pair;
    logic [NBITS-1:0] tw_re_d, tw_im_d, tw_re_q, tw_im_q;

    // Next-state logic: 8 issues per stage, fixed drain, single-cycle DONE
    always_comb begin
        state_d = state_q;
        j_d     = j_q;
        stage_d = stage_q;
        drain_d = drain_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = ISSUE;
                    j_d     = 3'd0;
                    stage_d = 2'd0;
                end
            end
            ISSUE: begin
                j_d = j_q + 3'd1;
                if (j_q == 3'd7) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end
            end
            DRAIN: begin
                if (drain_q == DW'(PIPE_D - 1)) begin
                    if (stage_q == 2'd3) begin
                        state_d = DONE;
                    end else begin
                        state_d = ISSUE;
                        stage_d = stage_q + 2'd1;
                    end
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                stage_d = 2'd0;
            end
            default: state_d = IDLE;
        endcase
        issue_d = (state_d == ISSUE);
    end

    // Butterfly operand addresses and twiddle index for the next issue
    always_comb begin
        span = 4'd1 << stage_d;
        idx  = {1'b0, j_d} & (span - 4'd1);
        grp  = {1'b0, j_d} >> stage_d;
        a_d  = 4'(grp << ({1'b0, stage_d} + 3'd1)) | idx;
        b_d  = a_d + span;
        k_d  = 3'(idx << (2'd3 - stage_d));
    end

    // Twiddle ROM, looked up for the issue that is MEM_LAT cycles old so the
    // registered value lands one cycle after the operand data
    always_comb begin
        tw_pair = 32'h0000_0000;
        if (pv[MEM_LAT-1]) begin
            case (pk[MEM_LAT-1])
                3'd0: tw_pair = 32'h4000_0000;
                3'd1: tw_pair = 32'h3B21_E782;
                3'd2: tw_pair = 32'h2D41_D2BF;
                3'd3: tw_pair = 32'h187E_C4DF;
                3'd4: tw_pair = 32'h0000_C000;
                3'd5: tw_pair = 32'hE782_C4DF;
                3'd6: tw_pair = 32'hD2BF_D2BF;
                3'd7: tw_pair = 32'hC4DF_E782;
                default: tw_pair = 32'h0000_0000;
            endcase
        end
        tw_re_d = NBITS'($signed(tw_pair[31:16]));
        tw_im_d = NBITS'($signed(tw_pair[15:0]));
    end

    // State, counters, issue registers and the write-back delay line
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            j_q     <= '0;
            stage_q <= '0;
            drain_q <= '0;
            rd_en_q <= 1'b0;
            ra_q    <= '0;
            rb_q    <= '0;
            k_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tw_re_q <= '0;
            tw_im_q <= '0;
            for (int i = 0; i < PIPE_D; i++) begin
                pv[i] <= 1'b0;
                pa[i] <= '0;
                pb[i] <= '0;
            end
            for (int i = 0; i < MEM_LAT; i++) begin
                pk[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            stage_q <= stage_d;
            drain_q <= drain_d;
            rd_en_q <= issue_d;
            ra_q    <= issue_d ? a_d : 4'd0;
            rb_q    <= issue_d ? b_d : 4'd0;
            k_q     <= issue_d ? k_d : 3'd0;
            busy_q  <= (state_d == ISSUE) || (state_d == DRAIN);
            done_q  <= (state_d == DONE);
            tw_re_q <= tw_re_d;
            tw_im_q <= tw_im_d;
            pv[0]   <= rd_en_q;
            pa[0]   <= ra_q;
            pb[0]   <= rb_q;
            for (int i = 1; i < PIPE_D; i++) begin
                pv[i] <= pv[i-1];
                pa[i] <= pa[i-1];
                pb[i] <= pb[i-1];
            end
            pk[0] <= k_q;
            for (int i = 1; i < MEM_LAT; i++) begin
                pk[i] <= pk[i-1];
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.rd_en     = rd_en_q;
    assign bus.rd_addr_a = ra_q;
    assign bus.rd_addr_b = rb_q;
    assign bus.wr_en     = pv[PIPE_D-1];
    assign bus.wr_addr_a = pa[PIPE_D-1];
    assign bus.wr_addr_b = pb[PIPE_D-1];
    assign bus.tw_re     = tw_re_q;
    assign bus.tw_im     = tw_im_q;
    assign bus.stage     = stage_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_fft16_ctrl.sv
// Bench for fft16_ctrl: directed checks of reset, issue/write/twiddle timing,
// held start, mid-transform reset, end-to-end transforms through a behavioural
// memory + butterfly, and twiddle legality under random start/reset.
module tb_fft16_ctrl;
    localparam int NBITS = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    fft16_ctrl_if #(.NBITS(NBITS)) bus ();

    fft16_ctrl #(.NBITS(NBITS), .MEM_LAT(1), .BF_LAT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic        rd_en;
        logic [3:0]  ra, rb;
        logic        wr_en;
        logic [3:0]  wa, wb;
        logic [15:0] twr, twi;
        logic        busy, done;
        logic [1:0]  stage;
    } cap_t;
    cap_t cap [160];

    int exp_a [4][8] = '{'{0,2,4,6,8,10,12,14}, '{0,1,4,5,8,9,12,13},
                         '{0,1,2,3,8,9,10,11}, '{0,1,2,3,4,5,6,7}};
    int exp_b [4][8] = '{'{1,3,5,7,9,11,13,15}, '{2,3,6,7,10,11,14,15},
                         '{4,5,6,7,12,13,14,15}, '{8,9,10,11,12,13,14,15}};
    int exp_k [4][8] = '{'{0,0,0,0,0,0,0,0}, '{0,4,0,4,0,4,0,4},
                         '{0,2,4,6,0,2,4,6}, '{0,1,2,3,4,5,6,7}};
    int stage_base [4] = '{1, 14, 27, 40};
    logic [15:0] tw_re_tab [8] = '{16'h4000, 16'h3B21, 16'h2D41, 16'h187E,
                                   16'h0000, 16'hE782, 16'hD2BF, 16'hC4DF};
    logic [15:0] tw_im_tab [8] = '{16'h0000, 16'hE782, 16'hD2BF, 16'hC4DF,
                                   16'hC000, 16'hC4DF, 16'hD2BF, 16'hE782};

    // ---------------- memory + butterfly model ----------------
    logic signed [15:0] mem_re [16];
    logic signed [15:0] mem_im [16];
    logic signed [15:0] init_re [16];
    logic signed [15:0] init_im [16];
    logic load_req = 1'b0;
    logic [63:0] m_ab, s1, s2, s3, s4;

    function automatic logic [63:0] bfly(input logic signed [15:0] ar, ai, br, bi, wr, wi);
        int pr, pi;
        pr = (int'(br) * int'(wr) - int'(bi) * int'(wi)) >>> 14;
        pi = (int'(br) * int'(wi) + int'(bi) * int'(wr)) >>> 14;
        return {16'((int'(ar) + pr) >>> 1), 16'((int'(ai) + pi) >>> 1),
                16'((int'(ar) - pr) >>> 1), 16'((int'(ai) - pi) >>> 1)};
    endfunction

    function automatic int bitrev4(input int v);
        return ((v & 1) << 3) | ((v & 2) << 1) | ((v & 4) >> 1) | ((v & 8) >> 3);
    endfunction

    function automatic bit in_issue(input int c);
        return (c >= 1 && c <= 8) || (c >= 14 && c <= 21) ||
               (c >= 27 && c <= 34) || (c >= 40 && c <= 47);
    endfunction

    // 1-cycle memory read, 4-register butterfly, write-back on wr_en
    always @(posedge clk) begin
        if (bus.rd_en) begin
            m_ab <= {mem_re[bus.rd_addr_a], mem_im[bus.rd_addr_a],
                     mem_re[bus.rd_addr_b], mem_im[bus.rd_addr_b]};
        end
        s1 <= m_ab;
        s2 <= bfly(s1[63:48], s1[47:32], s1[31:16], s1[15:0], bus.tw_re, bus.tw_im);
        s3 <= s2;
        s4 <= s3;
        if (load_req) begin
            for (int i = 0; i < 16; i++) begin
                mem_re[i] <= init_re[i];
                mem_im[i] <= init_im[i];
            end
        end else if (bus.wr_en) begin
            mem_re[bus.wr_addr_a] <= s4[63:48];
            mem_im[bus.wr_addr_a] <= s4[47:32];
            mem_re[bus.wr_addr_b] <= s4[31:16];
            mem_im[bus.wr_addr_b] <= s4[15:0];
        end
    end

    // ---------------- driver ----------------
    // Cycle c: outputs sampled at the negedge inside cycle c, then start/rst_n
    // are driven for sampling at the end of cycle c. Start is high for
    // c <= start_last; rst_n is low during cycle rst_cyc only.
    task automatic run(input int n, input int start_last, input int rst_cyc);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            cap[c].rd_en = bus.rd_en;
            cap[c].ra    = bus.rd_addr_a;
            cap[c].rb    = bus.rd_addr_b;
            cap[c].wr_en = bus.wr_en;
            cap[c].wa    = bus.wr_addr_a;
            cap[c].wb    = bus.wr_addr_b;
            cap[c].twr   = bus.tw_re;
            cap[c].twi   = bus.tw_im;
            cap[c].busy  = bus.busy;
            cap[c].done  = bus.done;
            cap[c].stage = bus.stage;
            bus.start = (c <= start_last);
            rst_n     = (c != rst_cyc);
        end
        @(negedge clk);
        bus.start = 1'b0;
        rst_n     = 1'b1;
    endtask

    task automatic load_mem();
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [51:0] got;
        rst_n     = 1'b0;
        bus.start = 1'b1;
        repeat (3) @(negedge clk);
        got = {bus.busy, bus.done, bus.rd_en, bus.wr_en, bus.rd_addr_a, bus.rd_addr_b,
               bus.wr_addr_a, bus.wr_addr_b, bus.stage, bus.dbg_state};
        n_total++;
        if (got[27:0] !== 28'h0) $display("FAIL reset_ctrl: got %h want 0", got[27:0]);
        else n_pass++;
        n_total++;
        if ({bus.tw_re, bus.tw_im} !== 32'h0)
            $display("FAIL reset_tw: got %h want 00000000", {bus.tw_re, bus.tw_im});
        else n_pass++;
        bus.start = 1'b0;
        rst_n     = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        int t;
        run(60, 0, -1);
        for (int s = 0; s < 4; s++) begin
            for (int j = 0; j < 8; j++) begin
                t = stage_base[s] + j;
                n_total++;
                if ({cap[t].rd_en, cap[t].ra, cap[t].rb, cap[t].stage} !==
                    {1'b1, 4'(exp_a[s][j]), 4'(exp_b[s][j]), 2'(s)})
                    $display("FAIL issue s%0d j%0d c%0d: got en=%b a=%0d b=%0d st=%0d want a=%0d b=%0d",
                             s, j, t, cap[t].rd_en, cap[t].ra, cap[t].rb, cap[t].stage,
                             exp_a[s][j], exp_b[s][j]);
                else n_pass++;
                n_total++;
                if ({cap[t+2].twr, cap[t+2].twi} !== {tw_re_tab[exp_k[s][j]], tw_im_tab[exp_k[s][j]]})
                    $display("FAIL twiddle s%0d j%0d c%0d: got %h_%h want %h_%h", s, j, t + 2,
                             cap[t+2].twr, cap[t+2].twi, tw_re_tab[exp_k[s][j]], tw_im_tab[exp_k[s][j]]);
                else n_pass++;
                n_total++;
                if ({cap[t+5].wr_en, cap[t+5].wa, cap[t+5].wb} !==
                    {1'b1, 4'(exp_a[s][j]), 4'(exp_b[s][j])})
                    $display("FAIL write s%0d j%0d c%0d: got en=%b a=%0d b=%0d want a=%0d b=%0d",
                             s, j, t + 5, cap[t+5].wr_en, cap[t+5].wa, cap[t+5].wb,
                             exp_a[s][j], exp_b[s][j]);
                else n_pass++;
            end
        end
        for (int c = 0; c < 60; c++) begin
            n_total++;
            if ({cap[c].rd_en, cap[c].wr_en, cap[c].busy, cap[c].done} !==
                {in_issue(c), in_issue(c - 5), (c >= 1 && c <= 52), (c == 53)})
                $display("FAIL strobes c%0d: got rd/wr/busy/done=%b%b%b%b want %b%b%b%b", c,
                         cap[c].rd_en, cap[c].wr_en, cap[c].busy, cap[c].done,
                         in_issue(c), in_issue(c - 5), (c >= 1 && c <= 52), (c == 53));
            else n_pass++;
            if (!in_issue(c - 2)) begin
                n_total++;
                if ({cap[c].twr, cap[c].twi} !== 32'h0)
                    $display("FAIL tw_idle c%0d: got %h_%h want 0000_0000", c, cap[c].twr, cap[c].twi);
                else n_pass++;
            end
        end
    endtask

    task automatic test_start_held();
        int n_done = 0;
        run(116, 60, -1);
        for (int c = 0; c < 116; c++) begin
            n_total++;
            if ({cap[c].rd_en, cap[c].busy, cap[c].done} !==
                {in_issue(c) || in_issue(c - 54), (c >= 1 && c <= 52) || (c >= 55 && c <= 106),
                 (c == 53) || (c == 107)})
                $display("FAIL held c%0d: got rd/busy/done=%b%b%b", c,
                         cap[c].rd_en, cap[c].busy, cap[c].done);
            else n_pass++;
            if (cap[c].done === 1'b1) n_done++;
        end
        n_total++;
        if (n_done !== 2) $display("FAIL held_done_count: got %0d want 2", n_done);
        else n_pass++;
        n_total++;
        if ({cap[54].rd_en, cap[55].rd_en} !== 2'b01)
            $display("FAIL held_restart: got rd54/rd55=%b%b want 01", cap[54].rd_en, cap[55].rd_en);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        run(40, 0, 20);
        n_total++;
        if ({cap[20].rd_en, cap[20].busy, cap[20].stage} !== {1'b1, 1'b1, 2'd1})
            $display("FAIL mid_pre c20: got rd/busy/stage=%b%b%0d want 1 1 1",
                     cap[20].rd_en, cap[20].busy, cap[20].stage);
        else n_pass++;
        for (int c = 21; c < 40; c++) begin
            n_total++;
            if ({cap[c].wr_en, cap[c].rd_en, cap[c].busy, cap[c].done} !== 4'b0000)
                $display("FAIL mid_flush c%0d: got wr/rd/busy/done=%b%b%b%b want 0000", c,
                         cap[c].wr_en, cap[c].rd_en, cap[c].busy, cap[c].done);
            else n_pass++;
        end
        run(60, 0, -1);
        for (int c = 0; c < 60; c++) begin
            n_total++;
            if ({cap[c].rd_en, cap[c].wr_en, cap[c].busy, cap[c].done} !==
                {in_issue(c), in_issue(c - 5), (c >= 1 && c <= 52), (c == 53)})
                $display("FAIL mid_rerun c%0d: got rd/wr/busy/done=%b%b%b%b", c,
                         cap[c].rd_en, cap[c].wr_en, cap[c].busy, cap[c].done);
            else n_pass++;
        end
    endtask

    task automatic test_e2e_dc();
        for (int i = 0; i < 16; i++) begin
            init_re[bitrev4(i)] = 16'sh0080;
            init_im[bitrev4(i)] = 16'sh0000;
        end
        load_mem();
        run(60, 0, -1);
        for (int k = 0; k < 16; k++) begin
            n_total++;
            if ({mem_re[k], mem_im[k]} !== {((k == 0) ? 16'h0080 : 16'h0000), 16'h0000})
                $display("FAIL dc X%0d: got %h_%h want %h_0000", k, mem_re[k], mem_im[k],
                         (k == 0) ? 16'h0080 : 16'h0000);
            else n_pass++;
        end
    endtask

    task automatic test_e2e_impulse();
        for (int i = 0; i < 16; i++) begin
            init_re[bitrev4(i)] = (i == 0) ? 16'sh0400 : 16'sh0000;
            init_im[bitrev4(i)] = 16'sh0000;
        end
        load_mem();
        run(60, 0, -1);
        for (int k = 0; k < 16; k++) begin
            n_total++;
            if ({mem_re[k], mem_im[k]} !== {16'h0040, 16'h0000})
                $display("FAIL impulse X%0d: got %h_%h want 0040_0000", k, mem_re[k], mem_im[k]);
            else n_pass++;
        end
    endtask

    task automatic test_random_legal();
        logic prev_rst;
        logic legal;
        prev_rst = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            legal = ({bus.tw_re, bus.tw_im} == 32'h0);
            for (int k = 0; k < 8; k++)
                if ({bus.tw_re, bus.tw_im} == {tw_re_tab[k], tw_im_tab[k]}) legal = 1'b1;
            n_total++;
            if (legal !== 1'b1)
                $display("FAIL tw_legal c%0d: got %h_%h not a legal pair", c, bus.tw_re, bus.tw_im);
            else n_pass++;
            if (!prev_rst) begin
                n_total++;
                if ({bus.wr_en, bus.rd_en, bus.busy, bus.done} !== 4'b0000)
                    $display("FAIL rand_flush c%0d: got wr/rd/busy/done=%b%b%b%b want 0000", c,
                             bus.wr_en, bus.rd_en, bus.busy, bus.done);
                else n_pass++;
            end
            bus.start = ($urandom_range(0, 3) == 0);
            rst_n     = ($urandom_range(0, 40) != 0);
            prev_rst  = rst_n;
        end
        @(negedge clk);
        bus.start = 1'b0;
        rst_n     = 1'b1;
    endtask

    initial begin
        bus.start = 1'b0;
        test_reset();
        test_single();
        test_start_held();
        test_reset_mid();
        test_e2e_dc();
        test_e2e_impulse();
        test_random_legal();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/fft16_ctrl.md
# fft16_ctrl

Sequencer for the 16-point radix-2 DIT FFT datapath. It owns the working sample memory's read and write ports and the butterfly's twiddle inputs. It steps through 4 stages of 8 butterflies each, presents the twiddle aligned to the butterfly's internal registering, and writes results back in place after the pipeline latency. Input samples are loaded bit-reversed by the capture logic; the result is left in natural order.

## Interface
- NBITS, 16, twiddle and datapath word width (Q2.14 twiddles)
- MEM_LAT, 1, cycles from rd_en/rd_addr to data at butterfly A/B inputs
- BF_LAT, 4, cycles from butterfly A/B inputs to X/Y outputs
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  request one transform; sampled only in IDLE
- busy  out  1  high while a transform is in progress
- done  out  1  one-cycle pulse when the final write has been issued
- rd_en  out  1  memory read strobe
- rd_addr_a, rd_addr_b  out  4 each  butterfly operand addresses
- wr_en  out  1  memory write strobe, for both X and Y
- wr_addr_a, wr_addr_b  out  4 each  X goes to a, Y goes to b
- tw_re, tw_im  out  NBITS each  twiddle to butterfly Wr/Wi
- stage  out  2  stage of the current issue

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE→ISSUE when start=1.
  - ISSUE issues 8 butterflies, one per cycle, then goes to DRAIN.
  - DRAIN waits until the stage's last write has gone out. It then returns to ISSUE with stage+1, or goes to DONE after stage 3.
  - DONE lasts 1 cycle, then returns to IDLE.
- Addressing for stage s (0..3) and butterfly j (0..7):
  - span=1<<s, g=j>>s, idx=j&(span-1)
  - a=g·2·span+idx, b=a+span
  - twiddle index k=idx<<(3−s)
- Twiddle ROM, W^k=exp(−j2πk/16), {tw_re, tw_im} per k:
  - k0 {4000,0000}, k1 {3B21,E782}, k2 {2D41,D2BF}, k3 {187E,C4DF}
  - k4 {0000,C000}, k5 {E782,C4DF}, k6 {D2BF,D2BF}, k7 {C4DF,E782}
  - The butterfly decodes only these exact codes (plus {0000,0000}). No other value may ever appear on tw_re/tw_im.
- When no butterfly needs a twiddle, tw_re=tw_im=0x0000.
- Write-back uses a valid/address shift register of depth MEM_LAT+BF_LAT. It carries {a,b}, and wr_en is the delayed issue strobe.
- start while busy, or in DONE, is ignored and not queued.
- If rst_n=0 in any state, the next cycle is IDLE with all counters cleared and the pending write pipeline flushed. No stale wr_en may follow.

## Timing
- Reset values: busy=0, done=0, rd_en=0, wr_en=0, all addresses=0, tw_re=tw_im=0, stage=0. Every output is registered.
- Cycle 0 is the cycle in which start is sampled high in IDLE.
- For an issue in cycle t:
  - rd_en=1 and rd_addr valid in cycle t.
  - A/B data reaches the butterfly at t+MEM_LAT.
  - tw_re/tw_im are valid in cycle t+MEM_LAT+1. The butterfly registers B before its twiddle-dependent product, so the twiddle lags the data by one cycle.
  - wr_en and wr_addr are valid at t+MEM_LAT+BF_LAT (t+5 with defaults).
- Read-after-write hazard: the first read of stage s+1 happens the cycle after the last write of stage s.
  - With defaults, stage issue windows are cycles 1–8, 14–21, 27–34 and 40–47.
  - Writes fall in issue+5 windows; the last write is cycle 52.
- busy is high in cycles 1–52. done=1 in cycle 53 only, with busy=0 in that cycle. The block accepts a new start from cycle 54.
- Stage gap is MEM_LAT+BF_LAT+1 cycles and must scale with the parameters.
- Datapath scaling: each butterfly outputs (A±BW)/2, so a full transform produces X[k]=DFT/16.

## Test plan
- Reset: hold rst_n=0 for 3 cycles.
  - Required: every output at its reset value.
  - Required: tw_re/tw_im=0x0000.
- Single transform with an address/twiddle scoreboard:
  - Cycle 1: a=0, b=1, tw in cycle 3 = {4000,0000}.
  - Stage 1, j=3 (cycle 17): a=5, b=7, tw={0000,C000}.
  - Stage 3, j=5 (cycle 45): a=5, b=13, tw={E782,C4DF}.
  - Every write = issue+5 with the same {a,b}.
  - done exactly in cycle 53.
- start held high continuously:
  - Required: exactly one transform per IDLE entry.
  - Required: second transform's first rd_en in cycle 55.
  - Required: no starts accepted while busy.
- rst_n low in cycle 20 (mid stage 1, with 5 writes in flight):
  - Required: from cycle 21, wr_en=0, rd_en=0, busy=0.
  - Required: a subsequent start yields a clean 53-cycle transform.
- End-to-end with the butterfly and a 1-cycle-read memory model:
  - All 16 samples 0x0080 → X[0]=0x0080, X[1..15]=0x0000.
  - Impulse x[0]=0x0400 → all X[k]=0x0040 (real), imaginary parts 0.
- Twiddle legality assertion: over random start/reset sequences, {tw_re,tw_im} is always one of the 9 legal pairs.
